// File: rtl/board_io_pkg.sv
// Shared constants and types for the DE2 board input front end.
// Key indices, switch field positions and debounce FSM states.
package board_io_pkg;

  localparam int KEY_STEP = 0;
  localparam int KEY_RUN  = 1;
  localparam int KEY_SEL  = 2;
  localparam int KEY_WORD = 3;

  localparam int SW_HALF_SEL = 16;

  localparam int DB_CYCLES_DEFAULT = 500000;

  typedef enum logic {
    STABLE_UP,
    STABLE_DN
  } db_state_t;

endpackage

// File: rtl/key_debounce.sv
// One-key synchronizer + debounce FSM; press pulses once per accepted fall.
// Ports: clk, rst_n, key_n_raw (async, 0=pressed), stable (1=up), press.
module key_debounce
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_raw,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             ks;
  db_state_t        st;
  db_state_t        st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      ks <= 1'b1;
    end else begin
      s1 <= key_n_raw;
      ks <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= STABLE_UP;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  // Any cycle agreeing with the stable level restarts the count,
  // so only an unbroken run of DB_CYCLES disagreements flips it.
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    unique case (st)
      STABLE_UP: begin
        if (!ks) begin
          if (cnt == CNT_LAST) begin
            st_nxt    = STABLE_DN;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      STABLE_DN: begin
        if (ks) begin
          if (cnt == CNT_LAST) begin
            st_nxt = STABLE_UP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
    endcase
  end

  assign stable = (st == STABLE_UP);

endmodule

// File: rtl/board_input_ctrl.sv
// DE2 input front end: debounced KEYs drive step/run/select/word entry.
// Ports: clk, rst_n, key_n[3:0], sw[17:0] -> step_pulse, run_mode,
// cpu_en, selm[2:0], word_out[31:0], word_load.
module board_input_ctrl
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  output logic        step_pulse,
  output logic        run_mode,
  output logic        cpu_en,
  output logic [2:0]  selm,
  output logic [31:0] word_out,
  output logic        word_load
);

  logic [3:0]  stable;
  logic [3:0]  press;
  logic [16:0] sw_q1;
  logic [16:0] sw_q2;
  logic        unused_ok;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_raw (key_n[i]),
      .stable    (stable[i]),
      .press     (press[i])
    );
  end

  // sw[17] is reserved; stable levels are not needed here.
  assign unused_ok = ^{sw[17], stable};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= sw[16:0];
      sw_q2 <= sw_q1;
    end
  end

  // All four key actions are independent and apply on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pulse <= 1'b0;
      run_mode   <= 1'b0;
      selm       <= 3'd0;
      word_out   <= 32'd0;
      word_load  <= 1'b0;
    end else begin
      step_pulse <= press[KEY_STEP];
      word_load  <= press[KEY_WORD];
      if (press[KEY_RUN]) begin
        run_mode <= ~run_mode;
      end
      if (press[KEY_SEL]) begin
        selm <= selm + 3'd1;
      end
      if (press[KEY_WORD]) begin
        if (sw_q2[SW_HALF_SEL]) begin
          word_out[31:16] <= sw_q2[15:0];
        end else begin
          word_out[15:0] <= sw_q2[15:0];
        end
      end
    end
  end

  assign cpu_en = run_mode | step_pulse;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Self-checking bench for board_input_ctrl with DB_CYCLES=4.
// Directed scenarios plus random key/switch traffic against a model.
module tb_board_input_ctrl;
  import board_io_pkg::*;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [17:0] sw = 18'd0;
  logic        step_pulse;
  logic        run_mode;
  logic        cpu_en;
  logic [2:0]  selm;
  logic [31:0] word_out;
  logic        word_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_input_ctrl #(
    .DB_CYCLES (DB),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .sw         (sw),
    .step_pulse (step_pulse),
    .run_mode   (run_mode),
    .cpu_en     (cpu_en),
    .selm       (selm),
    .word_out   (word_out),
    .word_load  (word_load)
  );

  logic [38:0] dut_vec;
  assign dut_vec = {step_pulse, run_mode, cpu_en,
                    selm, word_out, word_load};

  // Reference model: a key level is accepted once the raw samples
  // seen over DB consecutive edges (after a 2-edge sync delay) all
  // disagree with the current accepted level. Actions land one edge
  // after the accepting edge, using the switches from 2 edges earlier.
  logic [3:0]  kh[$];
  logic [17:0] swh[$];
  logic [3:0]  m_stable = 4'hF;
  logic [3:0]  m_fell = 4'h0;
  logic        m_step = 1'b0;
  logic        m_run = 1'b0;
  logic [2:0]  m_selm = 3'd0;
  logic [31:0] m_word = 32'd0;
  logic        m_load = 1'b0;
  logic [17:0] m_s2;
  int          m_e;
  bit          m_diff;

  function automatic logic raw(int k, int i);
    if (i < 1) return 1'b1;
    return kh[i-1][k];
  endfunction

  function automatic logic [38:0] exp_vec();
    return {m_step, m_run, m_run | m_step,
            m_selm, m_word, m_load};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kh.delete();
      swh.delete();
      m_stable = 4'hF;
      m_fell = 4'h0;
      m_step = 1'b0;
      m_run = 1'b0;
      m_selm = 3'd0;
      m_word = 32'd0;
      m_load = 1'b0;
    end else begin
      m_s2 = (swh.size() >= 2) ? swh[swh.size()-2] : 18'd0;
      m_step = m_fell[0];
      m_load = m_fell[3];
      if (m_fell[1]) m_run = ~m_run;
      if (m_fell[2]) m_selm = m_selm + 3'd1;
      if (m_fell[3]) begin
        if (m_s2[16]) m_word[31:16] = m_s2[15:0];
        else m_word[15:0] = m_s2[15:0];
      end
      kh.push_back(key_n);
      swh.push_back(sw);
      m_e = kh.size();
      m_fell = 4'h0;
      for (int k = 0; k < 4; k++) begin
        m_diff = 1'b1;
        for (int j = m_e - DB - 1; j <= m_e - 2; j++) begin
          if (raw(k, j) == m_stable[k]) m_diff = 1'b0;
        end
        if (m_diff) begin
          m_stable[k] = ~m_stable[k];
          if (!m_stable[k]) m_fell[k] = 1'b1;
        end
      end
    end
  end

  // Pulse counter sampled just after each edge.
  int load_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (word_load === 1'b1) load_cnt++;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_keys(logic [3:0] m);
    key_n = key_n & ~m;
    cyc(10);
    key_n = key_n | m;
    cyc(10);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    cyc(3);
    checks++;
    if (dut_vec !== 39'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=0", dut_vec);
    end
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (dut_vec !== 39'd0 || exp_vec() !== 39'd0) begin
      errors++;
      $display("FAIL reset_release got=%h want=0", dut_vec);
    end
  endtask

  task automatic test_step();
    int hits = 0;
    int at = -1;
    bit cpu_ok = 1'b1;
    bit model_ok = 1'b1;
    key_n[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dut_vec !== exp_vec()) model_ok = 1'b0;
      if (step_pulse) begin
        hits++;
        at = i;
        if (cpu_en !== 1'b1) cpu_ok = 1'b0;
      end
    end
    checks++;
    if (hits != 1 || at != DB + 3) begin
      errors++;
      $display("FAIL step_timing got hits=%0d at=%0d want 1 at %0d",
               hits, at, DB + 3);
    end
    checks++;
    if (!cpu_ok) begin
      errors++;
      $display("FAIL step_cpu_en got=0 want=1");
    end
    checks++;
    if (!model_ok) begin
      errors++;
      $display("FAIL step_model got=%h want=%h", dut_vec, exp_vec());
    end
    key_n[0] = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step_pulse) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL step_release got=%0d pulses want=0", hits);
    end
  endtask

  task automatic test_sel_bounce();
    logic [2:0] want;
    for (int i = 0; i < 6; i++) begin
      key_n[2] = (i % 2 == 1);
      cyc(2);
    end
    key_n[2] = 1'b1;
    cyc(12);
    checks++;
    if (selm !== 3'd0) begin
      errors++;
      $display("FAIL sel_bounce got=%0d want=0", selm);
    end
    for (int p = 0; p < 9; p++) begin
      press_keys(4'b0100);
      want = 3'((p + 1) % 8);
      checks++;
      if (selm !== want) begin
        errors++;
        $display("FAIL sel_press%0d got=%0d want=%0d", p, selm, want);
      end
    end
  endtask

  task automatic test_word();
    int l0;
    l0 = load_cnt;
    sw = {2'b10, 16'hBEEF};
    cyc(3);
    press_keys(4'b1000);
    checks++;
    if (word_out !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL word_lo got=%h want=0000beef", word_out);
    end
    sw = {2'b01, 16'hDEAD};
    cyc(3);
    press_keys(4'b1000);
    checks++;
    if (word_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_hi got=%h want=deadbeef", word_out);
    end
    checks++;
    if (load_cnt - l0 != 2) begin
      errors++;
      $display("FAIL word_load_cnt got=%0d want=2", load_cnt - l0);
    end
  endtask

  task automatic test_run();
    bit en_ok = 1'b1;
    press_keys(4'b0010);
    checks++;
    if (run_mode !== 1'b1 || cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL run_on got=%b%b want=11", run_mode, cpu_en);
    end
    key_n[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) key_n[0] = 1'b1;
      if (cpu_en !== 1'b1) en_ok = 1'b0;
    end
    checks++;
    if (!en_ok) begin
      errors++;
      $display("FAIL run_cpu_en_hold got=0 want=1");
    end
    press_keys(4'b0010);
    checks++;
    if (run_mode !== 1'b0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL run_off got=%b%b want=00", run_mode, cpu_en);
    end
  endtask

  task automatic test_simul();
    int ts = -1;
    int tsel = -1;
    key_n = key_n & ~4'b0101;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (step_pulse && ts < 0) ts = i;
      if (selm === 3'd2 && tsel < 0) tsel = i;
    end
    key_n = key_n | 4'b0101;
    cyc(10);
    checks++;
    if (ts != DB + 3 || tsel != DB + 3) begin
      errors++;
      $display("FAIL simul got step@%0d sel@%0d want both @%0d",
               ts, tsel, DB + 3);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    key_n[2] = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    checks++;
    if (dut_vec !== 39'd0) begin
      errors++;
      $display("FAIL rstmid_hold got=%h want=0", dut_vec);
    end
    rst_n = 1'b1;
    cyc(2);
    key_n[2] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dut_vec !== 39'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL rstmid_event got=%h want=0", dut_vec);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc=%0d got=%h want=%h",
                   i, dut_vec, exp_vec());
      end
      if ($urandom_range(5) == 0)
        key_n[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(19) == 0)
        sw = 18'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_sel_bounce();
    test_word();
    test_run();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
